// File: rtl/alu_addr_seq.sv
// -----------------------------------------------------------------------------
// alu_addr_seq
//
// Micro-sequencer for the 6502 ALU and its adder hold register. Accepts one
// operation at a time over a valid/ready handshake and steps the ALU and the
// hold-register bus enables through it cycle by cycle:
//   IDX_READ / IDX_WRITE : indexed effective address, with high-byte fixup
//                          when the low-byte add carries (page cross)
//   LSR / ROR            : one-bit shift right through the ALU shift path
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op/base/index/cin      operation and its operands
//   alu_a/alu_b/alu_cin/alu_sr ALU operand and function controls
//   alu_out/alu_cout           ALU result (combinational, same cycle)
//   add_load                   hold-register load strobe
//   add_adl_en/sb06_en/sb7_en  hold-register bus enables
//   addr/addr_valid/addr_dummy generated address and its qualifiers
//   res_valid/data/cout        shift result pulse
//
// Parameter
//   DUMMY_ON_WRITE  1: an indexed write always issues the pre-fixup address
//                      cycle, even without a page cross.
// -----------------------------------------------------------------------------
module alu_addr_seq #(
    parameter bit DUMMY_ON_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_base,
    input  logic [7:0]  req_index,
    input  logic        req_cin,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_sr,
    input  logic [7:0]  alu_out,
    input  logic        alu_cout,
    output logic        add_load,
    output logic        add_adl_en,
    output logic        add_sb06_en,
    output logic        add_sb7_en,
    output logic [15:0] addr,
    output logic        addr_valid,
    output logic        addr_dummy,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        res_cout
);

    typedef enum logic [1:0] {
        OP_IDX_READ  = 2'b00,
        OP_IDX_WRITE = 2'b01,
        OP_LSR       = 2'b10,
        OP_ROR       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD_LO,
        S_ADDR_LO,
        S_FIX_HI,
        S_ADDR_FIN,
        S_SHIFT,
        S_SHIFT_OUT
    } state_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  index_q, index_d;
    logic        cin_q, cin_d;
    logic [7:0]  sum_lo_q, sum_lo_d;
    logic        pc_q, pc_d;          // carry out of the low-byte add
    logic [7:0]  hi_q, hi_d;          // fixed-up high byte
    logic [6:0]  r_q, r_d;            // shift result; bit 7 comes from the controller
    logic        res_cout_q, res_cout_d;

    logic        needs_fix;
    logic        is_ror;

    // A write may be forced through the dummy cycle even when no page is crossed.
    assign needs_fix = pc_q || ((op_q == OP_IDX_WRITE) && DUMMY_ON_WRITE);
    assign is_ror    = (op_q == OP_ROR);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_IDX_READ;
            base_q     <= '0;
            index_q    <= '0;
            cin_q      <= 1'b0;
            sum_lo_q   <= '0;
            pc_q       <= 1'b0;
            hi_q       <= '0;
            r_q        <= '0;
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            index_q    <= index_d;
            cin_q      <= cin_d;
            sum_lo_q   <= sum_lo_d;
            pc_q       <= pc_d;
            hi_q       <= hi_d;
            r_q        <= r_d;
            res_cout_q <= res_cout_d;
        end
    end

    // Next-state and datapath-register logic.
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        base_d     = base_q;
        index_d    = index_q;
        cin_d      = cin_q;
        sum_lo_d   = sum_lo_q;
        pc_d       = pc_q;
        hi_d       = hi_q;
        r_d        = r_q;
        res_cout_d = res_cout_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    base_d  = req_base;
                    index_d = req_index;
                    cin_d   = req_cin;
                    state_d = req_op[1] ? S_SHIFT : S_ADD_LO;
                end
            end
            S_ADD_LO: begin
                sum_lo_d = alu_out;
                pc_d     = alu_cout;
                state_d  = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                state_d = needs_fix ? S_FIX_HI : S_IDLE;
            end
            S_FIX_HI: begin
                // Carry out of the high byte is dropped: FF wraps to 00.
                hi_d    = alu_out;
                state_d = S_ADDR_FIN;
            end
            S_ADDR_FIN: begin
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                r_d        = alu_out[6:0];
                res_cout_d = base_q[0];
                state_d    = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from state and latched request.
    always_comb begin
        req_ready   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_cin     = 1'b0;
        alu_sr      = 1'b0;
        add_load    = 1'b0;
        add_adl_en  = 1'b0;
        add_sb06_en = 1'b0;
        add_sb7_en  = 1'b0;
        addr        = '0;
        addr_valid  = 1'b0;
        addr_dummy  = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        res_cout    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_ADD_LO: begin
                alu_a    = base_q[7:0];
                alu_b    = index_q;
                add_load = 1'b1;
            end
            S_ADDR_LO: begin
                add_adl_en = 1'b1;
                addr       = {base_q[15:8], sum_lo_q};
                addr_valid = 1'b1;
                addr_dummy = needs_fix;
            end
            S_FIX_HI: begin
                alu_a    = base_q[15:8];
                alu_cin  = pc_q;
                add_load = 1'b1;
            end
            S_ADDR_FIN: begin
                addr       = {hi_q, sum_lo_q};
                addr_valid = 1'b1;
            end
            S_SHIFT: begin
                alu_sr   = 1'b1;
                alu_a    = base_q[7:0];
                alu_cin  = is_ror ? cin_q : 1'b0;
                add_load = 1'b1;
            end
            S_SHIFT_OUT: begin
                // LSR forces bit 7 to zero and leaves SB7 undriven.
                add_sb06_en = 1'b1;
                add_sb7_en  = is_ror;
                res_valid   = 1'b1;
                res_data    = {is_ror ? cin_q : 1'b0, r_q};
                res_cout    = res_cout_q;
            end
            default: begin
            end
        endcase
    end

endmodule
